// File: rtl/host_mem_mp.sv
// Multi-port OBI host memory: round-robin arbiter in front of one word array, fixed-latency
// in-order responses. Define HOST_MEM_DONE_DETECT_EN to enable the done_o completion flag.
module host_mem_mp #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned MEM_SIZE_WORD  = 32768,
    parameter int unsigned LATENCY        = 1,
    parameter int unsigned DONE_ADDR_WORD = 16384
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_PORTS-1:0]      req_i,
    input  logic [NUM_PORTS-1:0]      we_i,
    input  logic [4*NUM_PORTS-1:0]    be_i,
    input  logic [32*NUM_PORTS-1:0]   addr_i,
    input  logic [32*NUM_PORTS-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]      gnt_o,
    output logic [NUM_PORTS-1:0]      rvalid_o,
    output logic [32*NUM_PORTS-1:0]   rdata_o,
    output logic                      done_o
);
    localparam int unsigned PtrW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned AddrW = (MEM_SIZE_WORD > 1) ? $clog2(MEM_SIZE_WORD) : 1;

    logic [31:0] mem_array [MEM_SIZE_WORD];

    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] gnt;
    logic                 gnt_any;

    // Two passes: ports at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        ptr_d   = ptr_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (rst_ni && !gnt_any && req_i[p] && p >= 32'(ptr_q)) begin
                gnt[p]  = 1'b1;
                gnt_any = 1'b1;
                ptr_d   = (p + 1 == NUM_PORTS) ? '0 : PtrW'(p + 1);
            end
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (rst_ni && !gnt_any && req_i[p] && p < 32'(ptr_q)) begin
                gnt[p]  = 1'b1;
                gnt_any = 1'b1;
                ptr_d   = (p + 1 == NUM_PORTS) ? '0 : PtrW'(p + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    logic            sel_we;
    logic [3:0]      sel_be;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [PtrW-1:0] sel_port;

    always_comb begin
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_port  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                sel_we    = we_i[p];
                sel_be    = be_i[4*p +: 4];
                sel_addr  = addr_i[32*p +: 32];
                sel_wdata = wdata_i[32*p +: 32];
                sel_port  = PtrW'(p);
            end
        end
    end

    logic [31:0]      word_idx;
    logic             in_range;
    logic [AddrW-1:0] mem_idx;
    logic [31:0]      cur_word;
    logic [31:0]      merged;
    logic             wr_fire;
    logic [31:0]      rd_data;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^sel_addr[1:0];
    assign word_idx = {2'b00, sel_addr[31:2]};
    assign in_range = word_idx < MEM_SIZE_WORD;
    assign mem_idx  = word_idx[AddrW-1:0];
    assign cur_word = in_range ? mem_array[mem_idx] : 32'h0;
    assign wr_fire  = gnt_any & sel_we & in_range;
    assign rd_data  = sel_we ? 32'h0 : cur_word;

    always_comb begin
        merged = cur_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel_be[b]) merged[8*b +: 8] = sel_wdata[8*b +: 8];
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_array[mem_idx] <= merged;
    end

    logic            last_valid;
    logic [PtrW-1:0] last_port;
    logic [31:0]     last_data;

    // LATENCY-1 internal stages feed the per-port output registers, giving LATENCY in total.
    if (LATENCY > 1) begin : g_pipe
        logic [LATENCY-2:0] valid_q;
        logic [PtrW-1:0]    port_q [LATENCY-1];
        logic [31:0]        data_q [LATENCY-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                for (int unsigned s = 0; s < LATENCY - 1; s++) begin
                    port_q[s] <= '0;
                    data_q[s] <= '0;
                end
            end else begin
                valid_q[0] <= gnt_any;
                port_q[0]  <= sel_port;
                data_q[0]  <= rd_data;
                for (int unsigned s = 1; s < LATENCY - 1; s++) begin
                    valid_q[s] <= valid_q[s-1];
                    port_q[s]  <= port_q[s-1];
                    data_q[s]  <= data_q[s-1];
                end
            end
        end

        assign last_valid = valid_q[LATENCY-2];
        assign last_port  = port_q[LATENCY-2];
        assign last_data  = data_q[LATENCY-2];
    end else begin : g_nopipe
        assign last_valid = gnt_any;
        assign last_port  = sel_port;
        assign last_data  = rd_data;
    end

    logic [NUM_PORTS-1:0] rvalid_q;
    logic [31:0]          rdata_q [NUM_PORTS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rvalid_q[p] <= last_valid && (32'(last_port) == p);
                if (last_valid && (32'(last_port) == p)) rdata_q[p] <= last_data;
            end
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;

    always_comb begin
        rdata_o = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) rdata_o[32*p +: 32] = rdata_q[p];
    end

`ifdef HOST_MEM_DONE_DETECT_EN
    logic flag0_q, flag0_d, flag1_q, flag1_d, done_q, done_d;

    always_comb begin
        flag0_d = flag0_q;
        flag1_d = flag1_q;
        if (wr_fire && word_idx == DONE_ADDR_WORD)     flag0_d = (merged == 32'd1);
        if (wr_fire && word_idx == DONE_ADDR_WORD + 1) flag1_d = (merged == 32'd1);
        done_d = done_q | (wr_fire & flag0_d & flag1_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag0_q <= 1'b0;
            flag1_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            flag0_q <= flag0_d;
            flag1_q <= flag1_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;
`else
    assign done_o = 1'b0;
`endif

endmodule

// File: doc/host_mem_mp.md
HOST_MEM_MP -- requirements
Module: host_mem_mp

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, meaning the number of independent OBI requester ports (1..8).
REQ-002 The block SHALL have parameter MEM_SIZE_WORD, default 32768, meaning the storage depth in 32-bit words.
REQ-003 The block SHALL have parameter LATENCY, default 1, meaning the cycles from grant to rvalid (1..8).
REQ-004 The block SHALL have parameter DONE_ADDR_WORD, default 16384, meaning the word index of the two-word completion flag pair.
REQ-005 Clock and reset SHALL be the ports clk_i (input, 1, single clock) and rst_ni (input, 1); reset is asynchronous and active-low.
REQ-006 The block SHALL have port req_i, input, NUM_PORTS wide: per-port request.
REQ-007 The block SHALL have port we_i, input, NUM_PORTS wide: per-port write enable.
REQ-008 The block SHALL have port be_i, input, 4*NUM_PORTS wide: per-port byte enables.
REQ-009 The block SHALL have port addr_i, input, 32*NUM_PORTS wide: per-port byte address.
REQ-010 The block SHALL have port wdata_i, input, 32*NUM_PORTS wide: per-port write data.
REQ-011 The block SHALL have port gnt_o, output, NUM_PORTS wide: per-port grant.
REQ-012 The block SHALL have port rvalid_o, output, NUM_PORTS wide: per-port response valid.
REQ-013 The block SHALL have port rdata_o, output, 32*NUM_PORTS wide: per-port read data.
REQ-014 The block SHALL have port done_o, output, 1: kernel completion flag.

Function
REQ-015 Storage SHALL be one unpacked array mem_array[MEM_SIZE_WORD] of 32-bit words, so benches can preload and dump it directly.
REQ-016 At most one gnt_o bit SHALL be high per cycle; gnt_o SHALL be combinational from req_i and the priority pointer.
REQ-017 Arbitration SHALL be round-robin: the search starts at the pointer; after a grant to port k the pointer becomes (k+1) mod NUM_PORTS; with no grant the pointer holds.
REQ-018 Word index SHALL be addr[31:2]; addr[1:0] SHALL be ignored.
REQ-019 A granted write SHALL update only the bytes whose be bit is 1, at the clock edge ending the grant cycle.
REQ-020 A granted read SHALL sample mem_array at the grant edge, so a read granted the cycle after a write to the same word returns the new data.
REQ-021 For every grant (read or write), the granted port's rvalid_o SHALL pulse for exactly one cycle, LATENCY cycles after the grant cycle.
REQ-022 On that rvalid_o pulse, rdata_o SHALL carry the read word for a read and 0 for a write; rdata_o SHALL hold its last value when rvalid_o is low.
REQ-023 Responses SHALL be delivered in grant order through a LATENCY-deep shift pipeline that carries valid, port id and data; the pipeline SHALL never stall.
REQ-024 An out-of-range word index (>= MEM_SIZE_WORD) SHALL be granted normally; a write SHALL be dropped and a read SHALL return 32'h0.
REQ-025 A write with be = 4'b0000 SHALL leave the word unchanged but still produce a response.

Reset
REQ-026 While rst_ni = 0: gnt_o, rvalid_o, rdata_o and done_o SHALL all be 0; the pointer SHALL be 0 and the pipeline SHALL be empty.
REQ-027 Asserting reset mid-transaction SHALL discard in-flight responses, which SHALL never be delivered.
REQ-028 mem_array contents SHALL NOT be modified by reset.

Configuration
REQ-029 Macro HOST_MEM_DONE_DETECT_EN enables completion detection.
REQ-030 With HOST_MEM_DONE_DETECT_EN defined, done_o SHALL rise one cycle after a granted write leaves mem_array[DONE_ADDR_WORD] == 1 and mem_array[DONE_ADDR_WORD+1] == 1, and SHALL stay high until reset.
REQ-031 Under REQ-030, the flags SHALL be tracked in shadow registers updated on writes to those two words and cleared by reset.
REQ-032 Without HOST_MEM_DONE_DETECT_EN, done_o SHALL be tied to 0 and no shadow registers SHALL exist.

Verification
REQ-033 NUM_PORTS=2, LATENCY=1: port0 writes 0x12345678 to 0x100, then reads 0x100 -> gnt in the request cycle; rvalid 1 cycle later; rdata 0x12345678.
REQ-034 Both ports request every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; exactly one gnt bit per cycle.
REQ-035 LATENCY=3: word 0xAABBCCDD, write be=4'b0101 data 0x11223344, then read -> rvalid 3 cycles after each grant; read returns 0xAA22CC44.
REQ-036 Read at byte address 4*MEM_SIZE_WORD -> granted; rdata 0; memory unchanged.
REQ-037 With the macro defined: write 1 to DONE_ADDR_WORD, then 1 to DONE_ADDR_WORD+1 -> done_o high one cycle after the second write, held high; without the macro done_o stays 0.
REQ-038 Drop rst_ni one cycle after a read grant with LATENCY=2 -> no rvalid_o; all outputs 0; memory contents retained.
